// File: rtl/rf_init_check_pkg.sv
// ---------------------------------------------------------------------------
// rf_init_pkg
// Shared definitions for the register-file init/check sequencer:
//   - sequencer state encoding
//   - pattern-mode encodings
//   - register-file geometry (entry count and index width)
//   - pat(): the write pattern for a given mode and entry index
// ---------------------------------------------------------------------------
package rf_init_pkg;

  localparam int RF_NREGS = 32;
  localparam int RF_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_SQ   = 2'd0,  // i*i
    MODE_ID   = 2'd1,  // i
    MODE_NSQ  = 2'd2,  // ~(i*i)
    MODE_SEED = 2'd3   // seed ^ i
  } mode_e;

  // Pattern value for entry idx; all arithmetic is modulo 2^32.
  function automatic logic [31:0] pat(input logic [1:0]          mode,
                                      input logic [RF_IDX_W-1:0] idx,
                                      input logic [31:0]         seed);
    logic [31:0] i32;
    i32 = {27'd0, idx};
    case (mode)
      MODE_SQ:   pat = i32 * i32;
      MODE_ID:   pat = i32;
      MODE_NSQ:  pat = ~(i32 * i32);
      MODE_SEED: pat = seed ^ i32;
      default:   pat = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/rf_init_check_if.sv
// ---------------------------------------------------------------------------
// rf_init_check_if
// Bus between the init/check sequencer and the 32x32 register file.
//   wn/wd/w   : write index, write data, write enable (sequencer -> rf)
//   rn1/rn2   : read indices for the two read ports   (sequencer -> rf)
//   rd1/rd2   : read data, combinational from rn1/rn2 (rf -> sequencer)
// master = sequencer side, slave = register-file side.
// ---------------------------------------------------------------------------
interface rf_init_check_if;
  import rf_init_pkg::*;

  logic [RF_IDX_W-1:0] wn;
  logic [31:0]         wd;
  logic                w;
  logic [RF_IDX_W-1:0] rn1;
  logic [RF_IDX_W-1:0] rn2;
  logic [31:0]         rd1;
  logic [31:0]         rd2;

  modport master (
    output wn, wd, w, rn1, rn2,
    input  rd1, rd2
  );

  modport slave (
    input  wn, wd, w, rn1, rn2,
    output rd1, rd2
  );

endinterface

// File: rtl/rf_init_check_pattern_gen.sv
// ---------------------------------------------------------------------------
// rf_pattern_gen
// Purely combinational pattern / expected-value generator.
//   mode  : pattern select
//   idx   : register-file entry index
//   value : pat(mode, idx), or 0 for entry 0 when ZERO_R0 is set
// Used with ZERO_R0=0 for write data and ZERO_R0=SKIP_R0 for expected
// read-back values.
// ---------------------------------------------------------------------------
module rf_pattern_gen
  import rf_init_pkg::*;
#(
  parameter logic [31:0] SEED    = 32'hA5A5_5A5A,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic [1:0]          mode,
  input  logic [RF_IDX_W-1:0] idx,
  output logic [31:0]         value
);

  // Pattern lookup with optional forced-zero entry 0.
  always_comb begin
    if (ZERO_R0 && (idx == 5'd0)) begin
      value = 32'd0;
    end else begin
      value = pat(mode, idx, SEED);
    end
  end

endmodule

// File: rtl/rf_init_check.sv
// ---------------------------------------------------------------------------
// rf_init_check
// Writes every register-file entry with a selectable pattern, then reads all
// entries back two at a time and counts mismatches.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : begin a run (only honoured in IDLE or DONE)
//   mode            : pattern select, latched when start is accepted
//   rf              : register-file bus (master side)
//   busy            : run in progress (WRITE or READ)
//   done            : run finished; held until next accepted start/reset
//   pass            : no mismatches in the finished run
//   err_count       : number of mismatching entries (0..32)
//   first_err_addr  : lowest mismatching index, 0 if none
// All outputs are registers; nothing combinational reaches an output.
// ---------------------------------------------------------------------------
module rf_init_check
  import rf_init_pkg::*;
#(
  parameter int          NREGS   = 32,
  parameter bit          SKIP_R0 = 1'b0,
  parameter logic [31:0] SEED    = 32'hA5A5_5A5A
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  rf_init_check_if.master     rf,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [5:0]          err_count,
  output logic [RF_IDX_W-1:0] first_err_addr
);

  // Last write index and last read beat (two entries per beat).
  localparam logic [RF_IDX_W-1:0] LAST_WR = RF_IDX_W'(NREGS - 1);
  localparam logic [RF_IDX_W-1:0] LAST_RD = RF_IDX_W'(NREGS / 2 - 1);

  state_e              state_r,  state_nxt_s;
  logic [RF_IDX_W-1:0] idx_r,    idx_nxt_s;
  logic [1:0]          mode_r,   mode_nxt_s;
  logic                w_r,      w_nxt_s;
  logic [RF_IDX_W-1:0] wn_r,     wn_nxt_s;
  logic [31:0]         wd_r,     wd_nxt_s;
  logic [RF_IDX_W-1:0] rn1_r,    rn1_nxt_s;
  logic [RF_IDX_W-1:0] rn2_r,    rn2_nxt_s;
  logic                busy_r,   busy_nxt_s;
  logic                done_r,   done_nxt_s;
  logic                pass_r,   pass_nxt_s;
  logic [5:0]          err_r,    err_nxt_s;
  logic [RF_IDX_W-1:0] first_r,  first_nxt_s;

  logic [31:0]         wr_pat_s;
  logic [31:0]         exp1_s;
  logic [31:0]         exp2_s;
  logic                mis1_s;
  logic                mis2_s;
  logic [5:0]          mis_cnt_s;

  // Write data is generated from the *next* index/mode so it can be
  // registered alongside wn and w.
  rf_pattern_gen #(.SEED(SEED), .ZERO_R0(1'b0)) u_wr_gen (
    .mode  (mode_nxt_s),
    .idx   (wn_nxt_s),
    .value (wr_pat_s)
  );

  // Expected values for the entries currently addressed on the read ports.
  rf_pattern_gen #(.SEED(SEED), .ZERO_R0(SKIP_R0)) u_exp1_gen (
    .mode  (mode_r),
    .idx   (rn1_r),
    .value (exp1_s)
  );

  rf_pattern_gen #(.SEED(SEED), .ZERO_R0(SKIP_R0)) u_exp2_gen (
    .mode  (mode_r),
    .idx   (rn2_r),
    .value (exp2_s)
  );

  // Per-beat mismatch detection on both read ports.
  always_comb begin
    mis1_s    = (rf.rd1 != exp1_s);
    mis2_s    = (rf.rd2 != exp2_s);
    mis_cnt_s = {5'd0, mis1_s} + {5'd0, mis2_s};
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    mode_nxt_s  = mode_r;
    w_nxt_s     = 1'b0;
    wn_nxt_s    = 5'd0;
    rn1_nxt_s   = 5'd0;
    rn2_nxt_s   = 5'd0;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = done_r;
    pass_nxt_s  = pass_r;
    err_nxt_s   = err_r;
    first_nxt_s = first_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_nxt_s  = mode;
          done_nxt_s  = 1'b0;
          pass_nxt_s  = 1'b0;
          err_nxt_s   = 6'd0;
          first_nxt_s = 5'd0;
          idx_nxt_s   = 5'd0;
          state_nxt_s = ST_WRITE;
          w_nxt_s     = 1'b1;
          wn_nxt_s    = 5'd0;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end

      ST_WRITE: begin
        busy_nxt_s = 1'b1;
        if (idx_r == LAST_WR) begin
          // Last write lands on this edge; first read beat addresses 0/1.
          state_nxt_s = ST_READ;
          idx_nxt_s   = 5'd0;
          rn1_nxt_s   = 5'd0;
          rn2_nxt_s   = 5'd1;
        end else begin
          idx_nxt_s = idx_r + 5'd1;
          w_nxt_s   = 1'b1;
          wn_nxt_s  = idx_r + 5'd1;
        end
      end

      ST_READ: begin
        err_nxt_s = err_r + mis_cnt_s;
        // Only the first failing beat records an address; port 1 holds the
        // lower index so it wins a tie.
        if ((err_r == 6'd0) && mis1_s) begin
          first_nxt_s = rn1_r;
        end else if ((err_r == 6'd0) && mis2_s) begin
          first_nxt_s = rn2_r;
        end else begin
          first_nxt_s = first_r;
        end

        if (idx_r == LAST_RD) begin
          state_nxt_s = ST_DONE;
          idx_nxt_s   = 5'd0;
          done_nxt_s  = 1'b1;
          pass_nxt_s  = (err_nxt_s == 6'd0);
        end else begin
          idx_nxt_s  = idx_r + 5'd1;
          busy_nxt_s = 1'b1;
          rn1_nxt_s  = {idx_r[3:0] + 4'd1, 1'b0};
          rn2_nxt_s  = {idx_r[3:0] + 4'd1, 1'b1};
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = 5'd0;
        mode_nxt_s  = 2'd0;
        done_nxt_s  = 1'b0;
        pass_nxt_s  = 1'b0;
        err_nxt_s   = 6'd0;
        first_nxt_s = 5'd0;
      end
    endcase
  end

  // Write data is forced to zero whenever no write is issued.
  always_comb begin
    if (w_nxt_s) begin
      wd_nxt_s = wr_pat_s;
    end else begin
      wd_nxt_s = 32'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 5'd0;
      mode_r  <= 2'd0;
      w_r     <= 1'b0;
      wn_r    <= 5'd0;
      wd_r    <= 32'd0;
      rn1_r   <= 5'd0;
      rn2_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= 6'd0;
      first_r <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      mode_r  <= mode_nxt_s;
      w_r     <= w_nxt_s;
      wn_r    <= wn_nxt_s;
      wd_r    <= wd_nxt_s;
      rn1_r   <= rn1_nxt_s;
      rn2_r   <= rn2_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      pass_r  <= pass_nxt_s;
      err_r   <= err_nxt_s;
      first_r <= first_nxt_s;
    end
  end

  assign rf.w           = w_r;
  assign rf.wn          = wn_r;
  assign rf.wd          = wd_r;
  assign rf.rn1         = rn1_r;
  assign rf.rn2         = rn2_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_r;
  assign first_err_addr = first_r;

endmodule
